id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage RISC-V core, with integrated load-use hazard detection and bubble insertion.
- Captures decoded operands, register addresses, immediate and control bits from ID, and presents them to EX and to the forwarding unit.
- Generates the stall that freezes PC and IF/ID.
- Accepts the branch/jump flush from EX and the downstream memory hold.

---
 rtl/rv_pipe_pkg.sv | 24 ++
 rtl/id_ex_stage_hazard_detect.sv | 27 ++
 rtl/id_ex_stage.sv | 179 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline: default widths,
// control-word bit positions and the all-zero bubble control word.
package rv_pipe_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int REG_AW_DEFAULT = 5;

  // Control word layout: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc,
  // Branch, Jump, ALUOp[1:0]}
  localparam int CTRL_W         = 9;
  localparam int CTRL_REGWRITE  = 8;
  localparam int CTRL_MEMREAD   = 7;
  localparam int CTRL_MEMWRITE  = 6;
  localparam int CTRL_MEMTOREG  = 5;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_JUMP      = 2;
  localparam int CTRL_ALUOP_MSB = 1;
  localparam int CTRL_ALUOP_LSB = 0;

  // A bubble carries no side effects at all.
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = 9'b0_0000_0000;

endpackage : rv_pipe_pkg

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load sitting in EX whose destination is
// read by the instruction in ID must be separated by one bubble.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              flush,
  input  logic              hold,
  output logic              load_use,
  output logic              stall
);

  // Raw hazard, then suppressed when a flush kills ID or a hold already freezes upstream
  always_comb begin
    load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    stall    = load_use & ~flush & ~hold;
  end

endmodule : hazard_detect

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, WB write-through
// on the operand reads and a saturating count of inserted bubbles.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       stall_count
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic              ex_valid_q,    ex_valid_d;
  logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
  logic [REG_AW-1:0] ex_rs1_q,      ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q,      ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q,       ex_rd_d;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
  logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
  logic [31:0]       stall_count_q, stall_count_d;

  logic              load_use_s;
  logic              stall_s;
  logic              load_bubble_s;
  logic              load_id_s;
  logic [XLEN-1:0]   rs1_data_s;
  logic [XLEN-1:0]   rs2_data_s;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_rd       (ex_rd_q),
    .id_valid    (id_valid),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush       (flush),
    .hold        (hold),
    .load_use    (load_use_s),
    .stall       (stall_s)
  );

  // Operand capture: a same-cycle WB write to the read register wins over the stale RF data (never for x0)
  always_comb begin
    rs1_data_s = id_rs1_data;
    rs2_data_s = id_rs2_data;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) begin
      rs1_data_s = wb_data;
    end else begin
      rs1_data_s = id_rs1_data;
    end
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) begin
      rs2_data_s = wb_data;
    end else begin
      rs2_data_s = id_rs2_data;
    end
  end

  // Next stage contents: flush > hold > load-use/empty ID (bubble) > normal load; bubble count saturates
  always_comb begin
    load_bubble_s = flush | (~hold & (load_use_s | ~id_valid));
    load_id_s     = ~flush & ~hold & ~load_use_s & id_valid;

    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_ctrl_d     = ex_ctrl_q;
    stall_count_d = stall_count_q;

    if (load_bubble_s) begin
      ex_valid_d    = 1'b0;
      ex_pc_d       = '0;
      ex_rs1_d      = '0;
      ex_rs2_d      = '0;
      ex_rd_d       = '0;
      ex_rs1_data_d = '0;
      ex_rs2_data_d = '0;
      ex_imm_d      = '0;
      ex_ctrl_d     = BUBBLE_CTRL;
    end else if (load_id_s) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = id_pc;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_rd_d       = id_rd;
      ex_rs1_data_d = rs1_data_s;
      ex_rs2_data_d = rs2_data_s;
      ex_imm_d      = id_imm;
      ex_ctrl_d     = id_ctrl;
    end else begin
      ex_valid_d    = ex_valid_q;
    end

    if (stall_s && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Stage registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_ctrl_q     <= BUBBLE_CTRL;
      stall_count_q <= 32'd0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_ctrl_q     <= ex_ctrl_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall       = stall_s;
  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign stall_count = stall_count_q;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed instruction sequences, a behavioural
// model of the EX stage contents compared every cycle, plus literal checks.
module tb_id_ex_stage;

  localparam logic [8:0] LW_CTRL  = 9'h1B0;  // RegWrite, MemRead, MemtoReg, ALUSrc
  localparam logic [8:0] ADD_CTRL = 9'h102;  // RegWrite, ALUOp=2'b10

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [8:0]  id_ctrl;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, hold;
  logic        stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, stall_count;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [8:0]  ex_ctrl;

  int n_chk = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;
  logic preset_cnt = 1'b0;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [8:0]  ctrl;
  } ex_t;

  ex_t         m = '0;
  logic [31:0] m_cnt = 32'd0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .hold(hold), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hazard as the instruction-level rule: a valid load in EX writing a register ID reads
  function automatic logic model_load_use();
    return m.v && m.ctrl[7] && (m.rd != 5'd0) && id_valid &&
           ((id_use_rs1 && (id_rs1 == m.rd)) || (id_use_rs2 && (id_rs2 == m.rd)));
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] rf);
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs)) return wb_data;
    return rf;
  endfunction

  // Model: what EX must hold after each edge
  always @(posedge clk) begin
    logic        lu;
    logic [31:0] base;
    lu = model_load_use();
    if (!rst_n) begin
      m     = '0;
      m_cnt = 32'd0;
    end else begin
      base = preset_cnt ? 32'hFFFF_FFFD : m_cnt;
      if (flush) m = '0;
      else if (hold) m = m;
      else if (lu || !id_valid) m = '0;
      else m = '{1'b1, id_pc, id_rs1, id_rs2, id_rd,
                 pick(id_rs1, id_rs1_data), pick(id_rs2, id_rs2_data), id_imm, id_ctrl};
      if (lu && !flush && !hold && (base != 32'hFFFF_FFFF)) base = base + 32'd1;
      m_cnt = base;
    end
  end

  // Compare all outputs against the model away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_stall", {31'd0, stall}, {31'd0, model_load_use() && !flush && !hold});
      chk("m_valid", {31'd0, ex_valid}, {31'd0, m.v});
      chk("m_pc", ex_pc, m.pc);
      chk("m_rs1", {27'd0, ex_rs1}, {27'd0, m.rs1});
      chk("m_rs2", {27'd0, ex_rs2}, {27'd0, m.rs2});
      chk("m_rd", {27'd0, ex_rd}, {27'd0, m.rd});
      chk("m_d1", ex_rs1_data, m.d1);
      chk("m_d2", ex_rs2_data, m.d2);
      chk("m_imm", ex_imm, m.imm);
      chk("m_ctrl", {23'd0, ex_ctrl}, {23'd0, m.ctrl});
      chk("m_cnt", stall_count, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_pc = 32'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rs1_data = 32'd0; id_rs2_data = 32'd0;
    id_imm = 32'd0; id_ctrl = 9'd0; wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic [8:0] ctrl, input logic [31:0] d1, input logic [31:0] d2);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_ctrl = ctrl;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = pc + 32'h100;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
    step(); cmp_en = 1'b1; step();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_cnt", stall_count, 32'd0);
    rst_n = 1'b1;

    // plain flow
    drive(32'h10, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 9'h100, 32'h11, 32'h22);
    #1 chk("plain_stall", {31'd0, stall}, 32'd0);
    step(); set_idle();
    chk("plain_pc", ex_pc, 32'h10);
    chk("plain_rd", {27'd0, ex_rd}, 32'd5);
    chk("plain_valid", {31'd0, ex_valid}, 32'd1);

    // load-use: lw x5 then add reading x5
    drive(32'h14, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, LW_CTRL, 32'h1, 32'h0);
    step();
    drive(32'h18, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, ADD_CTRL, 32'h2, 32'h3);
    #1 chk("lu_stall", {31'd0, stall}, 32'd1);
    step();
    chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bub_ctrl", {23'd0, ex_ctrl}, 32'd0);
    chk("lu_cnt", stall_count, 32'd1);
    chk("lu_stall_clr", {31'd0, stall}, 32'd0);
    step();
    chk("lu_add_pc", ex_pc, 32'h18);
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    set_idle();

    // flush beats load-use, then flush without hazard
    drive(32'h20, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, LW_CTRL, 32'h1, 32'h0);
    step();
    drive(32'h24, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, ADD_CTRL, 32'h2, 32'h3);
    flush = 1'b1;
    #1 chk("fl_stall", {31'd0, stall}, 32'd0);
    step();
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_cnt", stall_count, 32'd1);
    drive(32'h28, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, ADD_CTRL, 32'h4, 32'h5);
    step();
    chk("fl_rd", {27'd0, ex_rd}, 32'd0);
    flush = 1'b0; set_idle();

    // hold freezes the stage
    drive(32'h40, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, ADD_CTRL, 32'h6, 32'h7);
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h50 + 32'(i) * 32'd4, 5'd3, 5'd4, 5'd10 + 5'(i), 1'b1, 1'b1, ADD_CTRL, 32'(i), 32'h9);
      step();
      chk("hold_pc", ex_pc, 32'h40);
    end
    hold = 1'b0;
    drive(32'h60, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, LW_CTRL, 32'h1, 32'h0);
    step();
    hold = 1'b1;
    drive(32'h64, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, ADD_CTRL, 32'h2, 32'h3);
    #1 chk("hold_lu_stall", {31'd0, stall}, 32'd0);
    step(); step();
    chk("hold_lu_pc", ex_pc, 32'h60);
    chk("hold_lu_cnt", stall_count, 32'd1);
    hold = 1'b0;
    #1 chk("hold_rel_stall", {31'd0, stall}, 32'd1);
    step();
    chk("hold_rel_cnt", stall_count, 32'd2);
    step();
    chk("hold_rel_pc", ex_pc, 32'h64);
    set_idle();

    // WB write-through and x0
    drive(32'h70, 5'd3, 5'd7, 5'd8, 1'b1, 1'b1, ADD_CTRL, 32'h3, 32'h1);
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    step();
    chk("wt_rs2", ex_rs2_data, 32'hDEAD_BEEF);
    chk("wt_rs1", ex_rs1_data, 32'h3);
    drive(32'h74, 5'd0, 5'd7, 5'd8, 1'b1, 1'b1, ADD_CTRL, 32'h55, 32'h1);
    wb_rd = 5'd0;
    step();
    chk("wt_x0_rs1", ex_rs1_data, 32'h55);
    chk("wt_x0_rs2", ex_rs2_data, 32'h1);
    set_idle();
    drive(32'h80, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, LW_CTRL, 32'h1, 32'h0);
    step();
    drive(32'h84, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, ADD_CTRL, 32'h0, 32'h0);
    #1 chk("x0_stall", {31'd0, stall}, 32'd0);
    step();
    chk("x0_pc", ex_pc, 32'h84);
    set_idle();

    // reset in the middle of a stall
    drive(32'h90, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, LW_CTRL, 32'h1, 32'h0);
    step();
    drive(32'h94, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, ADD_CTRL, 32'h2, 32'h3);
    #1 chk("rst_mid_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_mid_pc", ex_pc, 32'd0);
    chk("rst_mid_cnt", stall_count, 32'd0);
    chk("rst_mid_stall0", {31'd0, stall}, 32'd0);
    rst_n = 1'b1; set_idle();
    step();

    // saturation: preload near max, then alternate lw x5,0(x5) bubbles
    @(negedge clk);
    #2 force dut.stall_count_q = 32'hFFFF_FFFD;
    #1 release dut.stall_count_q;
    preset_cnt = 1'b1;
    step();
    preset_cnt = 1'b0;
    chk("sat_preset", stall_count, 32'hFFFF_FFFD);
    drive(32'hA0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, LW_CTRL, 32'h8, 32'h0);
    for (int i = 0; i < 6; i++) step();
    chk("sat_max", stall_count, 32'hFFFF_FFFF);
    set_idle();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule : tb_id_ex_stage
